// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory request and
// response channels, and the decoded-instruction stream toward decode.
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;

  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc_plus4;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_ready,
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst_data, inst_pc, inst_pc_plus4
  );

  // Environment side: branch unit, instruction memory and decode
  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_ready,
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst_data, inst_pc, inst_pc_plus4
  );

endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch front end. Issues sequential fetch requests under a
// credit limit, tracks in-flight requests with an in-order pc queue, buffers
// returned instructions in a DEPTH-entry FIFO, and on a redirect flushes the
// FIFO and discards every response still in flight.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input logic          CLK,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  cnt_t            outstanding_q, outstanding_d;
  cnt_t            drop_cnt_q, drop_cnt_d;
  cnt_t            count_q, count_d;
  ptr_t            head_q, head_d;
  ptr_t            tail_q, tail_d;
  ptr_t            pcq_head_q, pcq_head_d;
  ptr_t            pcq_tail_q, pcq_tail_d;

  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [XLEN-1:0] fifo_instr_d [DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] fifo_pc_d    [DEPTH];
  logic [XLEN-1:0] pcq_mem_q    [DEPTH];
  logic [XLEN-1:0] pcq_mem_d    [DEPTH];

  logic            req_valid;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [CW:0]     credit_used;

  // Handshake decode. Credit counts FIFO entries plus live (not-to-be-dropped)
  // requests so the FIFO can never overflow; in-flight requests are also
  // capped at DEPTH so back-to-back redirects cannot overrun the pc queue or
  // the outstanding counter.
  always_comb begin
    credit_used = {1'b0, count_q} + {1'b0, outstanding_q - drop_cnt_q};
    req_valid   = !reset && !bus.redirect_valid &&
                  (credit_used < DEPTH_W) && (outstanding_q < DEPTH_C);
    req_fire    = req_valid && bus.imem_req_ready;
    rsp_fire    = bus.imem_rsp_valid;
    rsp_drop    = (drop_cnt_q != '0);
    push        = rsp_fire && !rsp_drop && !bus.redirect_valid;
    pop         = (count_q != '0) && bus.inst_ready && !bus.redirect_valid;
  end

  // Next-state computation. A redirect takes priority: it reloads the fetch
  // pc, empties the FIFO and turns every request still in flight after this
  // cycle into one that must be dropped when its response arrives.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    pcq_head_d    = pcq_head_q;
    pcq_tail_d    = pcq_tail_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    pcq_mem_d     = pcq_mem_q;

    if (req_fire) begin
      pcq_mem_d[pcq_tail_q] = fetch_pc_q;
      pcq_tail_d            = pcq_tail_q + AW'(1);
    end
    if (rsp_fire) begin
      pcq_head_d = pcq_head_q + AW'(1);
    end

    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (rsp_fire && rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        fifo_instr_d[tail_q] = bus.imem_rsp_data;
        fifo_pc_d[tail_q]    = pcq_mem_q[pcq_head_q];
        tail_d               = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers with synchronous reset; reset abandons any
  // in-flight requests and restarts fetching at RESET_PC.
  always_ff @(posedge CLK) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      pcq_head_q    <= '0;
      pcq_tail_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      pcq_head_q    <= pcq_head_d;
      pcq_tail_q    <= pcq_tail_d;
    end
  end

  // Storage arrays need no reset; validity is tracked by the counters above.
  always_ff @(posedge CLK) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
    pcq_mem_q    <= pcq_mem_d;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = !reset && (count_q != '0);
  assign bus.inst_data      = fifo_instr_q[head_q];
  assign bus.inst_pc        = fifo_pc_q[head_q];
  assign bus.inst_pc_plus4  = fifo_pc_q[head_q] + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a long random
// run, all compared against a queue-based model of the fetch behaviour.
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic CLK = 1'b0;
  logic reset;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] addr; bit live; } inf_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  inf_t  inflight[$];
  ent_t  mfifo[$];
  mreq_t memq[$];
  logic [31:0] m_pc;

  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int rsp_pct = 100;
  int n_cmp = 0;
  int n_fail = 0;

  // Instruction memory contents as a pure function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Fetch may issue when FIFO entries plus live in-flight requests leave
  // room, and no more than DEPTH requests are in flight.
  function automatic bit exp_req_valid();
    int live = 0;
    foreach (inflight[i]) if (inflight[i].live) live++;
    return !reset && !bus.redirect_valid &&
           (mfifo.size() + live < DEPTH) && (inflight.size() < DEPTH);
  endfunction

  // One clock: memory responds, model follows the edge
  task automatic cycle();
    bit rsp, e_valid, e_pop, d_acc, red, rdy, rst;
    logic [31:0] d_addr, rp, rdata;
    inf_t f;
    rsp = 0;
    if (!reset && memq.size() > 0 && memq[0].due <= cyc &&
        $urandom_range(99) < rsp_pct) rsp = 1;
    rdata = rsp ? mem_word(memq[0].addr) : $urandom();
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rdata;
    #1;
    e_valid = exp_req_valid();
    e_pop   = !reset && !bus.redirect_valid && mfifo.size() != 0 && bus.inst_ready;
    d_acc   = bus.imem_req_valid && bus.imem_req_ready;
    d_addr  = bus.imem_req_addr;
    red     = bus.redirect_valid;
    rp      = bus.redirect_pc;
    rdy     = bus.imem_req_ready;
    rst     = reset;
    @(posedge CLK);
    if (rst) begin
      mfifo.delete();
      inflight.delete();
      memq.delete();
      m_pc = RESET_PC;
    end else begin
      if (e_pop) void'(mfifo.pop_front());
      if (rsp) begin
        void'(memq.pop_front());
        if (inflight.size() > 0) begin
          f = inflight.pop_front();
          if (f.live && !red) mfifo.push_back('{rdata, f.addr});
        end
      end
      if (d_acc) memq.push_back('{d_addr, cyc + $urandom_range(lat_max, lat_min)});
      if (e_valid && rdy) begin
        inflight.push_back('{m_pc, 1'b1});
        m_pc = m_pc + 32'd4;
      end
      if (red) begin
        mfifo.delete();
        foreach (inflight[i]) inflight[i].live = 0;
        m_pc = {rp[31:2], 2'b00};
      end
    end
    cyc++;
    @(negedge CLK);
    bus.imem_rsp_valid = 1'b0;
  endtask

  task automatic do_reset(input int lat, input bit iready);
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = iready;
    lat_min = lat;
    lat_max = lat;
    rsp_pct = 100;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (bus.imem_req_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
      end
      n_cmp++;
      if (bus.inst_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", bus.inst_valid);
      end
      cycle();
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
      n_fail++; $display("[TB] FAIL reset_first_req: got v=%b a=%h expected v=1 a=%h",
                         bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_startup();
    do_reset(1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC + 32'(4 * k)) begin
        n_fail++; $display("[TB] FAIL startup_req%0d: got v=%b a=%h expected v=1 a=%h", k,
                           bus.imem_req_valid, bus.imem_req_addr, RESET_PC + 32'(4 * k));
      end
      n_cmp++;
      if (bus.inst_valid !== (k >= 2)) begin
        n_fail++; $display("[TB] FAIL startup_inst_valid%0d: got %b expected %b", k, bus.inst_valid, k >= 2);
      end
      if (k == 2) begin
        n_cmp++;
        if (bus.inst_pc !== 32'h0 || bus.inst_pc_plus4 !== 32'h4 || bus.inst_data !== mem_word(32'h0)) begin
          n_fail++; $display("[TB] FAIL startup_first_inst: got pc=%h pc4=%h d=%h expected pc=0 pc4=4 d=%h",
                             bus.inst_pc, bus.inst_pc_plus4, bus.inst_data, mem_word(32'h0));
        end
      end
      cycle();
    end
  endtask

  task automatic test_credit();
    int acc = 0;
    do_reset(1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        n_cmp++;
        if (bus.imem_req_addr !== 32'(4 * acc)) begin
          n_fail++; $display("[TB] FAIL credit_addr: got %h expected %h", bus.imem_req_addr, 32'(4 * acc));
        end
        acc++;
      end
      cycle();
    end
    #1;
    n_cmp++;
    if (acc != 4) begin
      n_fail++; $display("[TB] FAIL credit_accepts: got %0d expected 4", acc);
    end
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
      n_fail++; $display("[TB] FAIL credit_full: got rv=%b iv=%b pc=%h expected rv=0 iv=1 pc=0",
                         bus.imem_req_valid, bus.inst_valid, bus.inst_pc);
    end
    bus.inst_ready = 1'b1;
    cycle();
    bus.inst_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus.imem_req_valid) begin
        n_cmp++;
        if (bus.imem_req_addr !== 32'h10) begin
          n_fail++; $display("[TB] FAIL credit_refill_addr: got %h expected 10", bus.imem_req_addr);
        end
        acc++;
      end
      cycle();
    end
    #1;
    n_cmp++;
    if (acc != 1 || bus.inst_pc !== 32'h4) begin
      n_fail++; $display("[TB] FAIL credit_refill: got accepts=%0d pc=%h expected accepts=1 pc=4", acc, bus.inst_pc);
    end
  endtask

  task automatic test_ready_stall();
    do_reset(1, 1'b1);
    cycle();
    cycle();
    bus.imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8) begin
        n_fail++; $display("[TB] FAIL stall_hold%0d: got v=%b a=%h expected v=1 a=8", k,
                           bus.imem_req_valid, bus.imem_req_addr);
      end
      cycle();
    end
    bus.imem_req_ready = 1'b1;
    cycle();
    #1;
    n_cmp++;
    if (bus.imem_req_addr !== 32'hC) begin
      n_fail++; $display("[TB] FAIL stall_advance: got %h expected c", bus.imem_req_addr);
    end
  endtask

  task automatic test_redirect_outstanding();
    bit seen = 0;
    do_reset(3, 1'b1);
    cycle();
    cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL redir_no_req: got %b expected 0", bus.imem_req_valid);
    end
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
      n_fail++; $display("[TB] FAIL redir_target: got v=%b a=%h expected v=1 a=100",
                         bus.imem_req_valid, bus.imem_req_addr);
    end
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (bus.inst_valid) begin
        seen = 1;
        n_cmp++;
        if (bus.inst_pc !== 32'h100 || bus.inst_data !== mem_word(32'h100)) begin
          n_fail++; $display("[TB] FAIL redir_first_inst: got pc=%h d=%h expected pc=100 d=%h",
                             bus.inst_pc, bus.inst_data, mem_word(32'h100));
        end
      end
      cycle();
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL redir_timeout: got no inst_valid expected inst at 100");
    end
  endtask

  task automatic test_redirect_rsp();
    bit seen = 0;
    do_reset(1, 1'b0);
    cycle();
    cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h2000_0041;
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL redir_rsp_no_req: got %b expected 0", bus.imem_req_valid);
    end
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL redir_rsp_flush: got %b expected 0", bus.inst_valid);
    end
    n_cmp++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h2000_0040) begin
      n_fail++; $display("[TB] FAIL redir_rsp_target: got v=%b a=%h expected v=1 a=20000040",
                         bus.imem_req_valid, bus.imem_req_addr);
    end
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (bus.inst_valid) begin
        seen = 1;
        n_cmp++;
        if (bus.inst_pc !== 32'h2000_0040) begin
          n_fail++; $display("[TB] FAIL redir_rsp_first_inst: got %h expected 20000040", bus.inst_pc);
        end
      end
      cycle();
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL redir_rsp_timeout: got no inst_valid expected inst at 20000040");
    end
  endtask

  task automatic test_wrap();
    bit seen = 0;
    do_reset(1, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("[TB] FAIL wrap_addr: got %h expected fffffffc", bus.imem_req_addr);
    end
    cycle();
    #1;
    n_cmp++;
    if (bus.imem_req_addr !== 32'h0) begin
      n_fail++; $display("[TB] FAIL wrap_next: got %h expected 0", bus.imem_req_addr);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (bus.inst_valid) begin
        seen = 1;
        n_cmp++;
        if (bus.inst_pc !== 32'hFFFF_FFFC || bus.inst_pc_plus4 !== 32'h0) begin
          n_fail++; $display("[TB] FAIL wrap_pc4: got pc=%h pc4=%h expected pc=fffffffc pc4=0",
                             bus.inst_pc, bus.inst_pc_plus4);
        end
      end
      cycle();
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL wrap_timeout: got no inst_valid expected inst at fffffffc");
    end
  endtask

  task automatic test_reset_midop();
    do_reset(1, 1'b0);
    for (int k = 0; k < 10 && mfifo.size() < 3; k++) cycle();
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || mfifo.size() != 3) begin
      n_fail++; $display("[TB] FAIL midrst_fill: got iv=%b entries=%0d expected iv=1 entries=3",
                         bus.inst_valid, mfifo.size());
    end
    reset = 1'b1;
    cycle();
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midrst_outputs: got iv=%b rv=%b expected 0 0",
                         bus.inst_valid, bus.imem_req_valid);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC || bus.inst_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midrst_restart: got rv=%b a=%h iv=%b expected rv=1 a=%h iv=0",
                         bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, RESET_PC);
    end
    cycle();
  endtask

  task automatic test_random();
    bit ev;
    do_reset(1, 1'b1);
    lat_min = 1;
    lat_max = 4;
    rsp_pct = 75;
    for (int k = 0; k < 3000; k++) begin
      reset              = ($urandom_range(999) < 3);
      bus.imem_req_ready = ($urandom_range(99) < 70);
      bus.inst_ready     = ($urandom_range(99) < 60);
      bus.redirect_valid = ($urandom_range(99) < 4);
      bus.redirect_pc    = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      #1;
      ev = exp_req_valid();
      n_cmp++;
      if (bus.imem_req_valid !== ev) begin
        n_fail++; $display("[TB] FAIL rand_req_valid@%0d: got %b expected %b", k, bus.imem_req_valid, ev);
      end
      if (ev) begin
        n_cmp++;
        if (bus.imem_req_addr !== m_pc) begin
          n_fail++; $display("[TB] FAIL rand_req_addr@%0d: got %h expected %h", k, bus.imem_req_addr, m_pc);
        end
      end
      n_cmp++;
      if (bus.inst_valid !== (!reset && mfifo.size() != 0)) begin
        n_fail++; $display("[TB] FAIL rand_inst_valid@%0d: got %b expected %b", k, bus.inst_valid,
                           !reset && mfifo.size() != 0);
      end
      if (!reset && mfifo.size() != 0) begin
        n_cmp++;
        if (bus.inst_data !== mfifo[0].data || bus.inst_pc !== mfifo[0].pc ||
            bus.inst_pc_plus4 !== mfifo[0].pc + 32'd4) begin
          n_fail++; $display("[TB] FAIL rand_head@%0d: got d=%h pc=%h pc4=%h expected d=%h pc=%h pc4=%h", k,
                             bus.inst_data, bus.inst_pc, bus.inst_pc_plus4,
                             mfifo[0].data, mfifo[0].pc, mfifo[0].pc + 32'd4);
        end
      end
      cycle();
    end
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b1;
    m_pc               = RESET_PC;
    $display("[TB] starting fetch_unit bench");
    test_reset();
    test_startup();
    test_credit();
    test_ready_stall();
    test_redirect_outstanding();
    test_redirect_rsp();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
